ex_fwd_unit: RTL and testbench

EX_FWD_UNIT -- requirements
Module: ex_fwd_unit

---
 rtl/ex_fwd_unit_pkg.sv | 16 +
 rtl/ex_fwd_unit_if.sv | 55 +++++
 rtl/ex_fwd_unit_fwd_select.sv | 43 ++++
 rtl/ex_fwd_unit.sv | 126 ++++++++++++
 tb/tb_ex_fwd_unit.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_fwd_unit_pkg.sv
// Shared definitions for the EX-stage forwarding and load-use stall unit:
// forwarding select encodings and the stall FSM state type.
package ex_fwd_unit_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

endpackage

// File: rtl/ex_fwd_unit_if.sv
// Pipeline-side bundle of the forwarding unit: ID/EX, EX/MEM and MEM/WB inputs
// plus the ALU operands, selects, store data and hazard controls it produces.
interface ex_fwd_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);

    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              idex_valid;
    logic              idex_memread;
    logic              idex_alusrc;
    logic [REG_AW-1:0] idex_rs;
    logic [REG_AW-1:0] idex_rt;
    logic [REG_AW-1:0] idex_rd;
    logic [DATA_W-1:0] idex_rdata1;
    logic [DATA_W-1:0] idex_rdata2;
    logic [DATA_W-1:0] idex_imm;
    logic              exmem_regwrite;
    logic              exmem_memread;
    logic [REG_AW-1:0] exmem_rd;
    logic [DATA_W-1:0] exmem_result;
    logic              memwb_regwrite;
    logic [REG_AW-1:0] memwb_rd;
    logic [DATA_W-1:0] memwb_result;
    logic              ex_adv;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic [DATA_W-1:0] exmem_store_data;
    logic              stall;
    logic              flush_idex;
    logic [15:0]       stall_cnt;

    modport master (
        output id_rs, id_rt, idex_valid, idex_memread, idex_alusrc,
               idex_rs, idex_rt, idex_rd, idex_rdata1, idex_rdata2, idex_imm,
               exmem_regwrite, exmem_memread, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result, ex_adv,
        input  alu_a, alu_b, fwd_sel_a, fwd_sel_b, exmem_store_data,
               stall, flush_idex, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, idex_valid, idex_memread, idex_alusrc,
               idex_rs, idex_rt, idex_rd, idex_rdata1, idex_rdata2, idex_imm,
               exmem_regwrite, exmem_memread, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result, ex_adv,
        output alu_a, alu_b, fwd_sel_a, fwd_sel_b, exmem_store_data,
               stall, flush_idex, stall_cnt
    );

endinterface

// File: rtl/ex_fwd_unit_fwd_select.sv
// Forwarding decision for one EX source register: picks the newest copy of the
// register among EX/MEM, MEM/WB and the register file.
module fwd_select
    import ex_fwd_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_exmem_regwrite,
    input  logic              i_exmem_memread,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_regwrite,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_result,
    output fwd_sel_t          o_sel,
    output logic [DATA_W-1:0] o_value
);

    logic w_mem_hit;
    logic w_wb_hit;

    // A load in EX/MEM has no data yet, so only ALU results forward from there.
    assign w_mem_hit = i_exmem_regwrite && !i_exmem_memread &&
                       (i_exmem_rd != '0) && (i_exmem_rd == i_src);
    assign w_wb_hit  = i_memwb_regwrite &&
                       (i_memwb_rd != '0) && (i_memwb_rd == i_src);

    always_comb begin
        o_sel   = FWD_RF;
        o_value = i_rf_data;
        if (w_mem_hit) begin
            o_sel   = FWD_MEM;
            o_value = i_exmem_result;
        end else if (w_wb_hit) begin
            o_sel   = FWD_WB;
            o_value = i_memwb_result;
        end
    end

endmodule

// File: rtl/ex_fwd_unit.sv
// EX-stage forwarding muxes, registered store data, and the load-use stall FSM
// that holds the front end for LOAD_LAT cycles per load-use hazard.
module ex_fwd_unit
    import ex_fwd_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    ex_fwd_unit_if.slave bus
);

    localparam int CNT_W = $clog2(LOAD_LAT) + 1;

    fwd_sel_t          w_sel_a;
    fwd_sel_t          w_sel_b;
    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_val_b;
    logic              w_hazard;
    logic              w_stall;
    stall_state_t      r_state;
    stall_state_t      w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_next_cnt;
    logic [DATA_W-1:0] r_store_data;
    logic [15:0]       r_stall_cnt;

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .i_src            (bus.idex_rs),
        .i_rf_data        (bus.idex_rdata1),
        .i_exmem_regwrite (bus.exmem_regwrite),
        .i_exmem_memread  (bus.exmem_memread),
        .i_exmem_rd       (bus.exmem_rd),
        .i_exmem_result   (bus.exmem_result),
        .i_memwb_regwrite (bus.memwb_regwrite),
        .i_memwb_rd       (bus.memwb_rd),
        .i_memwb_result   (bus.memwb_result),
        .o_sel            (w_sel_a),
        .o_value          (w_val_a)
    );

    fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .i_src            (bus.idex_rt),
        .i_rf_data        (bus.idex_rdata2),
        .i_exmem_regwrite (bus.exmem_regwrite),
        .i_exmem_memread  (bus.exmem_memread),
        .i_exmem_rd       (bus.exmem_rd),
        .i_exmem_result   (bus.exmem_result),
        .i_memwb_regwrite (bus.memwb_regwrite),
        .i_memwb_rd       (bus.memwb_rd),
        .i_memwb_result   (bus.memwb_result),
        .o_sel            (w_sel_b),
        .o_value          (w_val_b)
    );

    // Operand B may take the immediate, but stores always need the real rt value.
    assign bus.alu_a            = w_val_a;
    assign bus.alu_b            = bus.idex_alusrc ? bus.idex_imm : w_val_b;
    assign bus.fwd_sel_a        = w_sel_a;
    assign bus.fwd_sel_b        = w_sel_b;
    assign bus.exmem_store_data = r_store_data;
    assign bus.stall            = w_stall;
    assign bus.flush_idex       = w_stall;
    assign bus.stall_cnt        = r_stall_cnt;

    assign w_hazard = bus.idex_valid && bus.idex_memread && (bus.idex_rd != '0) &&
                      ((bus.idex_rd == bus.id_rs) || (bus.idex_rd == bus.id_rt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // The first stall cycle is spent in IDLE; STALL covers the remaining LOAD_LAT-1.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_hazard) begin
                    w_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_next_state = ST_STALL;
                        w_next_cnt   = CNT_W'(LOAD_LAT - 1);
                    end
                end
            end
            ST_STALL: begin
                w_stall    = 1'b1;
                w_next_cnt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_store_data <= '0;
        end else if (bus.ex_adv) begin
            r_store_data <= w_val_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ex_fwd_unit.sv
// Self-checking bench for ex_fwd_unit (LOAD_LAT=3): directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_ex_fwd_unit;
    import ex_fwd_unit_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LL = 3;

    typedef struct {
        logic [AW-1:0] id_rs, id_rt;
        logic          idex_valid, idex_memread, idex_alusrc;
        logic [AW-1:0] idex_rs, idex_rt, idex_rd;
        logic [DW-1:0] rdata1, rdata2, imm;
        logic          exmem_regwrite, exmem_memread;
        logic [AW-1:0] exmem_rd;
        logic [DW-1:0] exmem_result;
        logic          memwb_regwrite;
        logic [AW-1:0] memwb_rd;
        logic [DW-1:0] memwb_result;
        logic          ex_adv;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ex_fwd_unit_if #(.DATA_W(DW), .REG_AW(AW)) bus ();

    ex_fwd_unit #(.DATA_W(DW), .REG_AW(AW), .LOAD_LAT(LL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          nChecks = 0;
    int          nErrors = 0;
    bit          checking = 1'b0;
    int          mRem;
    logic [15:0] mStallCnt;
    logic [31:0] mStore;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Newest producer of a register: an ALU result still in MEM beats the value
    // about to be written back, which beats the register file. r0 never moves.
    function automatic logic [DW-1:0] newestValue(input logic [AW-1:0] r, input logic [DW-1:0] rf);
        if (r == 0) return rf;
        if (bus.exmem_regwrite && !bus.exmem_memread && bus.exmem_rd == r) return bus.exmem_result;
        if (bus.memwb_regwrite && bus.memwb_rd == r) return bus.memwb_result;
        return rf;
    endfunction

    function automatic logic [1:0] newestSource(input logic [AW-1:0] r);
        if (r == 0) return FWD_RF;
        if (bus.exmem_regwrite && !bus.exmem_memread && bus.exmem_rd == r) return FWD_MEM;
        if (bus.memwb_regwrite && bus.memwb_rd == r) return FWD_WB;
        return FWD_RF;
    endfunction

    function automatic bit loadUse();
        return bus.idex_valid && bus.idex_memread && bus.idex_rd != 0 &&
               (bus.idex_rd == bus.id_rs || bus.idex_rd == bus.id_rt);
    endfunction

    // mRem counts stall cycles still owed after the current one.
    function automatic bit expStall();
        return (mRem > 0) || loadUse();
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mRem      = 0;
            mStallCnt = 16'd0;
            mStore    = 32'd0;
        end else begin
            if (expStall() && mStallCnt != 16'hFFFF) mStallCnt = mStallCnt + 16'd1;
            if (bus.ex_adv) mStore = newestValue(bus.idex_rt, bus.idex_rdata2);
            if (mRem > 0) mRem = mRem - 1;
            else if (loadUse()) mRem = LL - 1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("m_alu_a", bus.alu_a, newestValue(bus.idex_rs, bus.idex_rdata1));
            checkOutput("m_sel_a", 32'(bus.fwd_sel_a), 32'(newestSource(bus.idex_rs)));
            checkOutput("m_alu_b", bus.alu_b,
                        bus.idex_alusrc ? bus.idex_imm : newestValue(bus.idex_rt, bus.idex_rdata2));
            checkOutput("m_sel_b", 32'(bus.fwd_sel_b), 32'(newestSource(bus.idex_rt)));
            checkOutput("m_stall", 32'(bus.stall), 32'(expStall()));
            checkOutput("m_flush", 32'(bus.flush_idex), 32'(expStall()));
            checkOutput("m_store", bus.exmem_store_data, mStore);
            checkOutput("m_stall_cnt", 32'(bus.stall_cnt), 32'(mStallCnt));
        end
    end

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        bus.id_rs          = v.id_rs;
        bus.id_rt          = v.id_rt;
        bus.idex_valid     = v.idex_valid;
        bus.idex_memread   = v.idex_memread;
        bus.idex_alusrc    = v.idex_alusrc;
        bus.idex_rs        = v.idex_rs;
        bus.idex_rt        = v.idex_rt;
        bus.idex_rd        = v.idex_rd;
        bus.idex_rdata1    = v.rdata1;
        bus.idex_rdata2    = v.rdata2;
        bus.idex_imm       = v.imm;
        bus.exmem_regwrite = v.exmem_regwrite;
        bus.exmem_memread  = v.exmem_memread;
        bus.exmem_rd       = v.exmem_rd;
        bus.exmem_result   = v.exmem_result;
        bus.memwb_regwrite = v.memwb_regwrite;
        bus.memwb_rd       = v.memwb_rd;
        bus.memwb_result   = v.memwb_result;
        bus.ex_adv         = v.ex_adv;
    endtask

    function automatic vec_t zeroVec();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    initial begin
        vec_t v;
        reset = 1'b1;
        applyStimulus(zeroVec());
        @(posedge clk);
        #1 reset = 1'b0;
        checking = 1'b1;

        @(negedge clk);
        checkOutput("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        checkOutput("rst_store", bus.exmem_store_data, 32'h0);
        checkOutput("rst_stall", 32'(bus.stall), 32'h0);

        // EX/MEM forward to rs
        v = zeroVec();
        v.exmem_regwrite = 1; v.exmem_rd = 5; v.exmem_result = 32'hAA;
        v.idex_rs = 5; v.rdata1 = 32'h11;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t1_sel_a", 32'(bus.fwd_sel_a), 32'h2);
        checkOutput("t1_alu_a", bus.alu_a, 32'hAA);

        // Both stages write r7: EX/MEM must win
        v = zeroVec();
        v.exmem_regwrite = 1; v.exmem_rd = 7; v.exmem_result = 32'h1234;
        v.memwb_regwrite = 1; v.memwb_rd = 7; v.memwb_result = 32'h5678;
        v.idex_rt = 7; v.rdata2 = 32'h99;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t2_sel_b", 32'(bus.fwd_sel_b), 32'h2);
        checkOutput("t2_alu_b", bus.alu_b, 32'h1234);

        // Immediate on B while store data still takes the forwarded rt
        v = zeroVec();
        v.memwb_regwrite = 1; v.memwb_rd = 3; v.memwb_result = 32'h55;
        v.idex_rt = 3; v.rdata2 = 32'h99; v.idex_alusrc = 1; v.imm = 32'h10; v.ex_adv = 1;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t3_alu_b", bus.alu_b, 32'h10);
        checkOutput("t3_sel_b", 32'(bus.fwd_sel_b), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("t3_store", bus.exmem_store_data, 32'h55);

        // ex_adv low: store data holds
        v.ex_adv = 0; v.memwb_result = 32'h66;
        applyStimulus(v);
        @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("t3_store_hold", bus.exmem_store_data, 32'h55);

        // r0 never forwards
        v = zeroVec();
        v.exmem_regwrite = 1; v.exmem_rd = 0; v.exmem_result = 32'hDEAD;
        v.idex_rs = 0; v.rdata1 = 32'h0;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t4_sel_a", 32'(bus.fwd_sel_a), 32'h0);
        checkOutput("t4_alu_a", bus.alu_a, 32'h0);

        // Load in EX/MEM falls through to MEM/WB
        v = zeroVec();
        v.exmem_regwrite = 1; v.exmem_memread = 1; v.exmem_rd = 6; v.exmem_result = 32'hBAD;
        v.memwb_regwrite = 1; v.memwb_rd = 6; v.memwb_result = 32'h77;
        v.idex_rs = 6; v.rdata1 = 32'h22;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t5_sel_a", 32'(bus.fwd_sel_a), 32'h1);
        checkOutput("t5_alu_a", bus.alu_a, 32'h77);

        // Load-use: exactly three stall cycles
        v = zeroVec();
        v.idex_valid = 1; v.idex_memread = 1; v.idex_rd = 4; v.id_rs = 4;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t6_stall_c1", 32'(bus.stall), 32'h1);
        checkOutput("t6_flush_c1", 32'(bus.flush_idex), 32'h1);
        v.idex_valid = 0;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t6_stall_c2", 32'(bus.stall), 32'h1);
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t6_stall_c3", 32'(bus.stall), 32'h1);
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t6_stall_c4", 32'(bus.stall), 32'h0);
        checkOutput("t6_stall_cnt", 32'(bus.stall_cnt), 32'h3);

        // Reset during the second stall cycle aborts the stall
        v.idex_valid = 1;
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t7_stall_c1", 32'(bus.stall), 32'h1);
        v.idex_valid = 0;
        applyStimulus(v);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("t7_stall_after_rst", 32'(bus.stall), 32'h0);
        checkOutput("t7_flush_after_rst", 32'(bus.flush_idex), 32'h0);
        checkOutput("t7_cnt_after_rst", 32'(bus.stall_cnt), 32'h0);
        applyStimulus(v);
        @(negedge clk);
        checkOutput("t7_stall_next", 32'(bus.stall), 32'h0);

        // Hazard held: a fresh stall starts right after the first one ends
        v.idex_valid = 1; v.id_rs = 0; v.id_rt = 4;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(v);
            @(negedge clk);
            checkOutput("t8_stall_held", 32'(bus.stall), 32'h1);
        end
        applyStimulus(zeroVec());
        @(negedge clk);
        checkOutput("t8_stall_tail1", 32'(bus.stall), 32'h1);
        applyStimulus(zeroVec());
        @(negedge clk);
        checkOutput("t8_stall_tail2", 32'(bus.stall), 32'h1);
        applyStimulus(zeroVec());
        @(negedge clk);
        checkOutput("t8_stall_done", 32'(bus.stall), 32'h0);
        checkOutput("t8_stall_cnt", 32'(bus.stall_cnt), 32'h6);

        // Mixed vectors over a small register range, checked by the model
        for (int i = 0; i < 300; i++) begin
            v = zeroVec();
            v.id_rs = AW'($urandom_range(0, 3));
            v.id_rt = AW'($urandom_range(0, 3));
            v.idex_valid = 1'($urandom_range(0, 1));
            v.idex_memread = ($urandom_range(0, 3) == 0);
            v.idex_alusrc = 1'($urandom_range(0, 1));
            v.idex_rs = AW'($urandom_range(0, 3));
            v.idex_rt = AW'($urandom_range(0, 3));
            v.idex_rd = AW'($urandom_range(0, 3));
            v.rdata1 = $urandom; v.rdata2 = $urandom; v.imm = $urandom;
            v.exmem_regwrite = 1'($urandom_range(0, 1));
            v.exmem_memread = 1'($urandom_range(0, 1));
            v.exmem_rd = AW'($urandom_range(0, 3));
            v.exmem_result = $urandom;
            v.memwb_regwrite = 1'($urandom_range(0, 1));
            v.memwb_rd = AW'($urandom_range(0, 3));
            v.memwb_result = $urandom;
            v.ex_adv = 1'($urandom_range(0, 1));
            applyStimulus(v);
        end

        // Continuous hazard long enough to saturate the stall counter
        v = zeroVec();
        v.idex_valid = 1; v.idex_memread = 1; v.idex_rd = 9; v.id_rt = 9;
        applyStimulus(v);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        checkOutput("t9_stall_cnt_sat", 32'(bus.stall_cnt), 32'hFFFF);
        checkOutput("t9_stall_sat", 32'(bus.stall), 32'h1);
        applyStimulus(zeroVec());
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("t9_stall_cnt_hold", 32'(bus.stall_cnt), 32'hFFFF);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
